// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The master side feeds bytes and observes the memory writes.
// The slave side is the loader itself.
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader.
// Parses a framed big-endian byte stream (length, words, checksum) and writes
// each word to instruction memory. The CPU is held in reset until the whole
// image is in memory and its checksum has been verified.
module imem_loader #(
   parameter int WORDS = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_reset,
   output logic          done,
   output logic          error
);

   localparam logic [15:0] WORDS_L = WORDS[15:0];

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] asm_q, asm_d;          // first three bytes of the word in flight
   logic [31:0] sum_q, sum_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        xfer;
   logic        enter_len;
   logic [15:0] len_full;
   logic [31:0] word_full;

   // A byte moves only while the loader is in one of the frame-parsing states
   assign xfer      = bus.rx_valid && bus.rx_ready;
   assign enter_len = start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);
   assign len_full  = {len_q[15:8], bus.rx_data};
   assign word_full = {asm_q, bus.rx_data};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: walk the frame fields, branch on length and checksum
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERR: begin
            if (start) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               if (len_full == 16'd0 || len_full > WORDS_L) state_d = S_ERR;
               else                                         state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && byte_cnt_q == 2'd3 && (idx_q + 16'd1) == len_q) state_d = S_CSUM;
         end
         S_CSUM: begin
            if (xfer && byte_cnt_q == 2'd3) begin
               state_d = (word_full == sum_q) ? S_RUN : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: handshake and CPU control come straight from the state
   always_comb begin
      bus.rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
      cpu_reset    = (state_q != S_RUN);
      done         = (state_q == S_RUN);
      error        = (state_q == S_ERR);
   end

   // Datapath next values: byte assembly, word writes, index and running sum
   always_comb begin
      len_d      = len_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      sum_d      = sum_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if (enter_len) begin
         idx_d      = 16'd0;
         byte_cnt_d = 2'd0;
         sum_d      = 32'd0;
      end
      if (xfer) begin
         case (state_q)
            S_LEN_HI: len_d = {bus.rx_data, 8'h00};
            S_LEN_LO: len_d = len_full;
            S_DATA, S_CSUM: begin
               asm_d      = word_full[23:0];
               byte_cnt_d = byte_cnt_q + 2'd1;
               // The write strobe is registered, so it appears the cycle after the 4th byte
               if (state_q == S_DATA && byte_cnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = {14'd0, idx_q, 2'b00};
                  wdata_d = word_full;
                  idx_d   = idx_q + 16'd1;
                  sum_d   = sum_q + word_full;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers; reset drops any partial word without writing it
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q      <= 16'd0;
         idx_q      <= 16'd0;
         byte_cnt_q <= 2'd0;
         asm_q      <= 24'd0;
         sum_q      <= 32'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
      end else begin
         len_q      <= len_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         sum_q      <= sum_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed and random frames against a
// frame-level reference model (expected writes, checksum outcome).
module tb_imem_loader;

   localparam int WORDS = 64;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic cpu_reset;
   logic done;
   logic error;

   imem_loader_if bus();

   imem_loader #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int n_vec    = 0;
   int n_err    = 0;
   int n_writes = 0;
   logic [7:0] frame_q[$];

   // Count every write pulse seen on the memory port
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) n_writes++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      chk("rst_rx_ready",   32'(bus.rx_ready), 32'd0);
      chk("rst_imem_we",    32'(bus.imem_we),  32'd0);
      chk("rst_imem_addr",  bus.imem_addr,     32'd0);
      chk("rst_imem_wdata", bus.imem_wdata,    32'd0);
      chk("rst_cpu_reset",  32'(cpu_reset),    32'd1);
      chk("rst_done",       32'(done),         32'd0);
      chk("rst_error",      32'(error),        32'd0);
   endtask

   function automatic logic [31:0] word_at(input int i);
      return {frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]};
   endfunction

   // Build a frame with a given length field, nw random words and an optionally corrupted checksum
   task automatic build_random(input int n_field, input int nw, input bit corrupt);
      logic [31:0] w;
      logic [31:0] s;
      logic [15:0] nf;
      s  = 32'd0;
      nf = n_field[15:0];
      frame_q.delete();
      frame_q.push_back(nf[15:8]);
      frame_q.push_back(nf[7:0]);
      for (int i = 0; i < nw; i++) begin
         w = $urandom;
         s = s + w;
         frame_q.push_back(w[31:24]);
         frame_q.push_back(w[23:16]);
         frame_q.push_back(w[15:8]);
         frame_q.push_back(w[7:0]);
      end
      if (corrupt) s = s ^ (32'd1 << $urandom_range(0, 31));
      frame_q.push_back(s[31:24]);
      frame_q.push_back(s[23:16]);
      frame_q.push_back(s[15:8]);
      frame_q.push_back(s[7:0]);
   endtask

   task automatic build_good_fixed();
      frame_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A,
                  8'h40, 8'h11, 8'h00, 8'h0F};
   endtask

   // Present one byte after 'gap' idle cycles and return the cycle after it is accepted
   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      bus.rx_valid = 1'b0;
      repeat (gap) tick();
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      w = 0;
      while (bus.rx_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) chk("ready_timeout", 32'(bus.rx_ready), 32'd1);
      tick();
      bus.rx_valid = 1'b0;
   endtask

   // Present bytes while the loader is not parsing; none may be taken
   task automatic idle_bytes();
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      repeat (3) begin
         chk("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
         tick();
      end
      bus.rx_valid = 1'b0;
   endtask

   // Start a load and stream frame_q; stop_after < 0 sends the whole frame
   task automatic run_frame(input int maxgap, input int stop_after);
      int          n;
      int          nbytes;
      int          w0;
      int          idx;
      bit          legal;
      bit          exp_we;
      bit          exp_run;
      logic [31:0] sum;
      logic [31:0] csum;
      n     = int'({frame_q[0], frame_q[1]});
      legal = (n >= 1 && n <= WORDS);
      sum   = 32'd0;
      csum  = 32'd0;
      if (legal) begin
         for (int i = 0; i < n; i++) sum = sum + word_at(i);
         csum = {frame_q[2+4*n], frame_q[3+4*n], frame_q[4+4*n], frame_q[5+4*n]};
      end
      nbytes = legal ? (2 + 4*n + 4) : 2;
      if (stop_after >= 0) nbytes = stop_after;
      w0 = n_writes;

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_cpu_reset", 32'(cpu_reset),    32'd1);
      chk("start_done",      32'(done),         32'd0);
      chk("start_error",     32'(error),        32'd0);
      chk("start_rx_ready",  32'(bus.rx_ready), 32'd1);

      for (int k = 0; k < nbytes; k++) begin
         send_byte(frame_q[k], $urandom_range(0, maxgap));
         exp_we = legal && k >= 2 && k < 2 + 4*n && ((k - 2) % 4 == 3);
         chk("imem_we", 32'(bus.imem_we), 32'(exp_we));
         if (exp_we) begin
            idx = (k - 2) / 4;
            chk("imem_addr",  bus.imem_addr,  32'(idx * 4));
            chk("imem_wdata", bus.imem_wdata, word_at(idx));
         end
      end

      if (stop_after < 0) begin
         exp_run = legal && (csum == sum);
         chk("end_done",      32'(done),      32'(exp_run));
         chk("end_cpu_reset", 32'(cpu_reset), 32'(!exp_run));
         chk("end_error",     32'(error),     32'(!exp_run));
         chk("end_nwrites",   32'(n_writes - w0), legal ? 32'(n) : 32'd0);
      end
   endtask

   initial begin
      int w_before;
      int nw;
      int nf;
      int r;
      reset        = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA5;
      tick();
      tick();
      check_reset_vals();
      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      tick();

      // Bytes in IDLE are not consumed
      idle_bytes();
      chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

      // Good load at full rate
      build_good_fixed();
      run_frame(0, -1);
      idle_bytes();
      chk("run_hold_done", 32'(done), 32'd1);

      // Bad checksum (restart from RUN)
      frame_q[13] = 8'h0E;
      run_frame(0, -1);
      idle_bytes();
      chk("err_hold_error", 32'(error), 32'd1);

      // Length bounds
      build_random(0, 0, 1'b0);
      run_frame(0, -1);
      build_random(65, 0, 1'b0);
      run_frame(0, -1);
      build_random(64, 64, 1'b0);
      run_frame(1, -1);

      // Handshake gaps
      build_good_fixed();
      run_frame(5, -1);

      // Abort after 6 data bytes: only the first complete word is written
      build_good_fixed();
      w_before = n_writes;
      run_frame(0, 8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_vals();
      repeat (3) tick();
      chk("abort_nwrites", 32'(n_writes - w_before), 32'd1);

      // Reset wins over a simultaneous start
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check_reset_vals();

      // Reload after abort, then restart from RUN
      build_good_fixed();
      run_frame(0, -1);
      build_good_fixed();
      run_frame(2, -1);

      // Randomized frames
      for (int it = 0; it < 20; it++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            build_random(0, 0, 1'b0);
         end else if (r == 1) begin
            nf = $urandom_range(WORDS + 1, 65535);
            build_random(nf, 0, 1'b0);
         end else begin
            nw = $urandom_range(1, 8);
            build_random(nw, nw, ($urandom_range(0, 3) == 0));
         end
         run_frame(5, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle CPU. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into instruction memory through a one-cycle write port. It holds the CPU in reset until a complete, checksum-verified program is in place.

## Interface
Parameters:
- `WORDS`, default 64: maximum program length in words; legal frame length is 1..WORDS.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin (or restart) a load.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out 32: byte address of the write, always word-aligned.
- `imem_wdata` out 32: instruction word to write.
- `cpu_reset` out 1: drives the CPU `reset`; high except in RUN.
- `done` out 1: program loaded and verified; high only in RUN.
- `error` out 1: frame rejected; high only in ERR.

## Operation
- **Frame format, all fields big-endian:**
  - 2 bytes: word count N.
  - N×4 bytes: instruction words.
  - 4 bytes: checksum, the 32-bit sum mod 2^32 of the N words. The length field is not included in the sum.
- **Byte transfer:** a byte transfers on a rising edge where `rx_valid && rx_ready`. `rx_data` is ignored otherwise.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR.
- **`rx_ready`:** decoded from the state register; high in LEN_HI, LEN_LO, DATA and CSUM, low in all other states.
- **IDLE:**
  - `start` moves to LEN_HI.
  - On entry to LEN_HI the word index, byte counter and running sum are cleared.
- **LEN_HI → LEN_LO:** on one transfer.
- **LEN_LO:**
  - On transfer, if N==0 or N>WORDS the next state is ERR.
  - Otherwise the next state is DATA.
- **DATA:**
  - Bytes shift into a 32-bit assembler, first byte into [31:24].
  - On the 4th byte of a word, the following cycle drives:
    - `imem_we`=1
    - `imem_addr`=index×4
    - `imem_wdata`=assembled word
  - In the same step the index increments and the sum accumulates the word.
  - When the Nth word's 4th byte is accepted, the next state is CSUM.
- **CSUM:**
  - Assemble 4 bytes.
  - On the 4th byte, go to RUN if the value equals the sum (including the final word), else go to ERR.
- **RUN:**
  - `cpu_reset`=0, `done`=1.
  - `start` re-enters LEN_HI: `cpu_reset` rises and `done` falls the next cycle.
- **ERR:**
  - `error`=1, `cpu_reset`=1.
  - `start` clears `error` and enters LEN_HI.
- **`start` handling:** `start` is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- **Width rules:**
  - The index counter is 16 bits.
  - `imem_addr` = {index, 2'b00}, zero-extended to 32 bits.
  - The sum wraps mod 2^32.

## Timing
- **Reset values:**
  - state IDLE
  - `rx_ready`=0, `imem_we`=0
  - `imem_addr`=0, `imem_wdata`=0
  - `cpu_reset`=1, `done`=0, `error`=0
- **Write latency:** `imem_we` asserts exactly 1 cycle after the 4th byte of each word is accepted. It is high for 1 cycle, with address and data valid in that cycle. `imem_addr`/`imem_wdata` hold their last values otherwise.
- **Back-to-back bytes:** at full rate (`rx_valid` continuously high) there is one byte per cycle. Writes are spaced 4 cycles apart and never overlap or drop.
- **Final write ordering:** the last word's write completes at least 3 cycles before RUN is entered, so the CPU never runs on a partially written image.
- **RUN timing:** `cpu_reset` falls and `done` rises in the cycle after the last checksum byte is accepted.
- **ERR timing:** `error` rises the cycle after the rejecting byte (LEN_LO or last CSUM byte).
- **Reset mid-operation:**
  - Everything returns to reset values next edge.
  - A partial word is discarded and no write is issued.
  - Words already written are not erased.
- **Simultaneous `reset` and `start`:** `reset` wins.

## Test plan
- **Reset:** assert `reset` 2 cycles with `rx_valid`=1 → all outputs at reset values, no transfer, `cpu_reset`=1.
- **Good load at full rate:**
  - Stimulus: `start`, then bytes 00 02 | 20 08 00 05 | 20 09 00 0A | 40 11 00 0F.
  - Expect two `imem_we` pulses: (addr 0x0, data 0x20080005) and (addr 0x4, data 0x2009000A).
  - Then `done`=1 and `cpu_reset`=0 the cycle after the final byte.
- **Bad checksum:** same frame with last byte 0E → `error`=1, `done`=0, `cpu_reset` stays 1. A following `start` clears `error`.
- **Length bounds:**
  - N=0 → ERR after 2nd byte.
  - N=65 (WORDS=64) → ERR.
  - N=64 with correct checksum → 64 writes, last at addr 0xFC, RUN.
- **Handshake gaps:** repeat the good load with random 0–5 idle cycles between bytes. Writes and RUN are identical to the full-rate case. Bytes presented in IDLE/RUN/ERR are not consumed.
- **Abort and reload:**
  - Assert `reset` after 6 data bytes → no write for the partial word.
  - A subsequent good load succeeds.
  - `start` while in RUN → `cpu_reset`=1 and `done`=0 next cycle, then reload completes.
